// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: queues whole chip-select transactions into a multi-CS SPI master and buffers RX bytes.
// Optional statistics counters (o_Xfer_Total, o_Drop_Total) exist only when SPI_XFER_SEQ_STATS_EN is defined.
module spi_xfer_sequencer #(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int NUM_SLAVES       = 4,
  parameter int RX_FIFO_DEPTH    = 4
) (
  input  logic                                  i_Clk,
  input  logic                                  i_Rst,
  input  logic                                  i_Cmd_Valid,
  output logic                                  o_Cmd_Ready,
  input  logic [$clog2(NUM_SLAVES)-1:0]         i_Cmd_Slave,
  input  logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] i_Cmd_Count,
  output logic                                  o_Cmd_Err,
  input  logic                                  i_Wr_Valid,
  input  logic [7:0]                            i_Wr_Byte,
  output logic                                  o_Wr_Ready,
  output logic                                  o_Rd_Valid,
  output logic [7:0]                            o_Rd_Byte,
  input  logic                                  i_Rd_Ready,
  output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_TX_Count,
  output logic [$clog2(NUM_SLAVES)-1:0]         o_Slave_Select,
  output logic [7:0]                            o_TX_Byte,
  output logic                                  o_TX_DV,
  input  logic                                  i_TX_Ready,
  input  logic                                  i_RX_DV,
  input  logic [7:0]                            i_RX_Byte,
  output logic                                  o_Busy,
  output logic                                  o_Done,
`ifdef SPI_XFER_SEQ_STATS_EN
  output logic [15:0]                           o_Xfer_Total,
  output logic [15:0]                           o_Drop_Total,
`endif
  output logic                                  o_Overflow
);

  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
  localparam int SW = $clog2(NUM_SLAVES);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BYTES_PER_CS);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SW-1:0]   r_slave;
  logic [CW-1:0]   r_tx_count;
  logic [CW-1:0]   r_tx_left;
  logic [CW-1:0]   r_rx_left;
  logic [1:0]      r_guard;
  logic [7:0]      r_tx_byte;
  logic            r_tx_dv;
  logic            r_cmd_err;
  logic            r_overflow;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [7:0]      r_mem [RX_FIFO_DEPTH];

  logic w_cmd_fire;
  logic w_cmd_ok;
  logic w_may_issue;
  logic w_issue;
  logic w_rx_take;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_cmd_fire  = (r_state == S_IDLE) && i_Cmd_Valid;
  assign w_cmd_ok    = (i_Cmd_Count != '0) && (i_Cmd_Count <= MAX_C);
  // The master drops ready one cycle after DV, so the guard masks i_TX_Ready until it is trustworthy.
  assign w_may_issue = (r_state == S_ISSUE) && (r_tx_left != '0) && (r_guard == 2'd0)
                       && i_TX_Ready && !r_tx_dv;
  assign w_issue     = w_may_issue && i_Wr_Valid;
  assign w_rx_take   = i_RX_DV && ((r_state == S_ISSUE) || (r_state == S_DRAIN));

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && i_Rd_Ready;
  assign w_push  = w_rx_take && (!w_full || w_pop);
  assign w_drop  = w_rx_take && w_full && !w_pop;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire && w_cmd_ok) begin
          w_next = S_ISSUE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (r_tx_left == '0) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (r_rx_left == '0) begin
          w_next = S_DONE;
        end else begin
          w_next = S_DRAIN;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_Cmd_Ready = 1'b0;
    o_Busy      = 1'b1;
    o_Done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_Cmd_Ready = 1'b1;
        o_Busy      = 1'b0;
      end
      S_DONE:  o_Done = 1'b1;
      default: o_Done = 1'b0;
    endcase
  end

  // Command latch, byte issue, remaining-byte counters and DV guard.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_slave    <= '0;
      r_tx_count <= '0;
      r_tx_left  <= '0;
      r_rx_left  <= '0;
      r_guard    <= 2'd0;
      r_tx_byte  <= 8'h00;
      r_tx_dv    <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_cmd_err <= w_cmd_fire && !w_cmd_ok;
      r_tx_dv   <= w_issue;
      if (w_cmd_fire && w_cmd_ok) begin
        r_slave    <= i_Cmd_Slave;
        r_tx_count <= i_Cmd_Count;
        r_tx_left  <= i_Cmd_Count;
        r_rx_left  <= i_Cmd_Count;
      end else begin
        if (w_issue) begin
          r_tx_left <= r_tx_left - ONE_C;
        end
        if (w_rx_take && (r_rx_left != '0)) begin
          r_rx_left <= r_rx_left - ONE_C;
        end
      end
      if (w_issue) begin
        r_tx_byte <= i_Wr_Byte;
        r_guard   <= 2'd2;
      end else if (r_guard != 2'd0) begin
        r_guard <= r_guard - 2'd1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the read port is masked while the FIFO is empty.
  always_ff @(posedge i_Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_RX_Byte;
    end
  end

  assign o_Rd_Valid     = !w_empty;
  assign o_Rd_Byte      = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_Wr_Ready     = w_may_issue;
  assign o_Cmd_Err      = r_cmd_err;
  assign o_TX_DV        = r_tx_dv;
  assign o_TX_Byte      = r_tx_byte;
  assign o_TX_Count     = r_tx_count;
  assign o_Slave_Select = r_slave;
  assign o_Overflow     = r_overflow;

`ifdef SPI_XFER_SEQ_STATS_EN
  logic [15:0] r_xfer_total;
  logic [15:0] r_drop_total;

  // Transfer total wraps; drop total saturates.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_xfer_total <= 16'd0;
      r_drop_total <= 16'd0;
    end else begin
      if (r_state == S_DONE) begin
        r_xfer_total <= r_xfer_total + 16'd1;
      end
      if (w_drop && (r_drop_total != 16'hFFFF)) begin
        r_drop_total <= r_drop_total + 16'd1;
      end
    end
  end

  assign o_Xfer_Total = r_xfer_total;
  assign o_Drop_Total = r_drop_total;
`endif

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer with a behavioural SPI master that echoes ~MOSI.
module tb_spi_xfer_sequencer;

  logic       clk;
  logic       i_Rst, i_Cmd_Valid, o_Cmd_Ready, o_Cmd_Err;
  logic [1:0] i_Cmd_Slave, i_Cmd_Count;
  logic       i_Wr_Valid, o_Wr_Ready, o_Rd_Valid, i_Rd_Ready;
  logic [7:0] i_Wr_Byte, o_Rd_Byte, o_TX_Byte, i_RX_Byte;
  logic [1:0] o_TX_Count, o_Slave_Select;
  logic       o_TX_DV, i_TX_Ready, i_RX_DV, o_Busy, o_Done, o_Overflow;
`ifdef SPI_XFER_SEQ_STATS_EN
  logic [15:0] o_Xfer_Total, o_Drop_Total;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int dv_count = 0;
  int done_count = 0;
  int err_count = 0;
  int last_dv = -100;
  logic [7:0] exp_q[$];
  bit m_hold = 1'b0;
  int m_cnt = 0;
  logic [7:0] m_byte = 8'h00;

  spi_xfer_sequencer #(.MAX_BYTES_PER_CS(2), .NUM_SLAVES(4), .RX_FIFO_DEPTH(4)) dut (
    .i_Clk(clk), .i_Rst(i_Rst),
    .i_Cmd_Valid(i_Cmd_Valid), .o_Cmd_Ready(o_Cmd_Ready),
    .i_Cmd_Slave(i_Cmd_Slave), .i_Cmd_Count(i_Cmd_Count), .o_Cmd_Err(o_Cmd_Err),
    .i_Wr_Valid(i_Wr_Valid), .i_Wr_Byte(i_Wr_Byte), .o_Wr_Ready(o_Wr_Ready),
    .o_Rd_Valid(o_Rd_Valid), .o_Rd_Byte(o_Rd_Byte), .i_Rd_Ready(i_Rd_Ready),
    .o_TX_Count(o_TX_Count), .o_Slave_Select(o_Slave_Select),
    .o_TX_Byte(o_TX_Byte), .o_TX_DV(o_TX_DV), .i_TX_Ready(i_TX_Ready),
    .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
    .o_Busy(o_Busy), .o_Done(o_Done),
`ifdef SPI_XFER_SEQ_STATS_EN
    .o_Xfer_Total(o_Xfer_Total), .o_Drop_Total(o_Drop_Total),
`endif
    .o_Overflow(o_Overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Master model: ready drops after DV, echoes ~byte some cycles later.
  initial begin
    i_TX_Ready = 1'b1;
    i_RX_DV    = 1'b0;
    i_RX_Byte  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      i_RX_DV = 1'b0;
      if (m_hold) i_TX_Ready = 1'b1;
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          i_RX_DV    = 1'b1;
          i_RX_Byte  = ~m_byte;
          i_TX_Ready = 1'b1;
        end
      end
      if (o_TX_DV) begin
        m_byte = o_TX_Byte;
        m_cnt  = m_hold ? 2 : 4;
        if (!m_hold) i_TX_Ready = 1'b0;
      end
    end
  end

  // Event monitor: counts pulses and checks DV spacing.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (o_TX_DV) begin
        n_cmp = n_cmp + 1;
        if (cyc - last_dv < 3) begin
          n_bad = n_bad + 1;
          $display("FAIL dv_spacing: gap %0d cycles, required >= 3", cyc - last_dv);
        end
        last_dv  = cyc;
        dv_count = dv_count + 1;
      end
      if (o_Done)    done_count = done_count + 1;
      if (o_Cmd_Err) err_count  = err_count + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    @(negedge clk);
    i_Rst = 1'b1;
    repeat (2) @(negedge clk);
    i_Rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_xfer(input logic [1:0] sl, input logic [1:0] cnt,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input bit chk_lat, input int stall);
    int t;
    int dv0;
    t = 0;
    @(negedge clk);
    while (!o_Cmd_Ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_ready_timeout: o_Cmd_Ready=%b, required 1", o_Cmd_Ready);
    end
    dv0 = dv_count;
    i_Cmd_Valid = 1'b1; i_Cmd_Slave = sl; i_Cmd_Count = cnt;
    i_Wr_Valid = 1'b1;  i_Wr_Byte = b0;
    @(negedge clk);
    i_Cmd_Valid = 1'b0;
    n_cmp++;
    if (o_Slave_Select !== sl || o_TX_Count !== cnt || o_Busy !== 1'b1) begin
      n_bad++;
      $display("FAIL cmd_latch: sel=%0d cnt=%0d busy=%b, required sel=%0d cnt=%0d busy=1",
               o_Slave_Select, o_TX_Count, o_Busy, sl, cnt);
    end
    if (chk_lat) begin
      n_cmp++;
      if (o_Wr_Ready !== 1'b1 || o_TX_DV !== 1'b0) begin
        n_bad++;
        $display("FAIL issue_entry: wr_ready=%b dv=%b, required wr_ready=1 dv=0", o_Wr_Ready, o_TX_DV);
      end
    end
    for (int i = 0; i < int'(cnt); i++) begin
      i_Wr_Valid = 1'b1;
      i_Wr_Byte  = (i == 0) ? b0 : b1;
      t = 0;
      while (!o_Wr_Ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin
        n_cmp++; n_bad++;
        $display("FAIL wr_ready_timeout: o_Wr_Ready=%b, required 1", o_Wr_Ready);
      end
      @(negedge clk);
      i_Wr_Valid = 1'b0;
      if (chk_lat && i == 0) begin
        n_cmp++;
        if (o_TX_DV !== 1'b1 || o_TX_Byte !== b0) begin
          n_bad++;
          $display("FAIL first_dv_latency: dv=%b byte=%h, required dv=1 byte=%h", o_TX_DV, o_TX_Byte, b0);
        end
      end
      if (stall > 0 && i == 0) begin
        repeat (stall) @(negedge clk);
        n_cmp++;
        if (dv_count !== dv0 + 1 || o_Busy !== 1'b1 || o_TX_Count !== cnt || o_Wr_Ready !== 1'b1) begin
          n_bad++;
          $display("FAIL stall: dvs=%0d busy=%b cnt=%0d wr_ready=%b, required dvs=%0d busy=1 cnt=%0d wr_ready=1",
                   dv_count - dv0, o_Busy, o_TX_Count, o_Wr_Ready, 1, cnt);
        end
      end
    end
    t = 0;
    while (!o_Done && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: o_Done=%b, required 1", o_Done);
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    logic [7:0] e;
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!o_Rd_Valid && t < 20) begin @(negedge clk); t++; end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (o_Rd_Valid !== 1'b1 || o_Rd_Byte !== e) begin
        n_bad++;
        $display("FAIL rx_data[%0d]: valid=%b byte=%h, required valid=1 byte=%h", i, o_Rd_Valid, o_Rd_Byte, e);
      end
      i_Rd_Ready = 1'b1;
      @(negedge clk);
      i_Rd_Ready = 1'b0;
    end
    n_cmp++;
    if (o_Rd_Valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fifo_empty: o_Rd_Valid=%b, required 0", o_Rd_Valid);
    end
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    repeat (3) @(negedge clk);
    i_Rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_Cmd_Err, o_Wr_Ready, o_Rd_Valid, o_TX_DV, o_Busy, o_Done, o_Overflow, o_Cmd_Ready} !== 8'b0000_0001) begin
      n_bad++;
      $display("FAIL reset_flags: err,wr,rd,dv,busy,done,ovf,cmd_rdy=%b, required 00000001",
               {o_Cmd_Err, o_Wr_Ready, o_Rd_Valid, o_TX_DV, o_Busy, o_Done, o_Overflow, o_Cmd_Ready});
    end
    n_cmp++;
    if (o_Rd_Byte !== 8'h00 || o_TX_Byte !== 8'h00 || o_TX_Count !== 2'd0 || o_Slave_Select !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_data: rd=%h tx=%h cnt=%0d sel=%0d, required all 0", o_Rd_Byte, o_TX_Byte, o_TX_Count, o_Slave_Select);
    end
`ifdef SPI_XFER_SEQ_STATS_EN
    n_cmp++;
    if (o_Xfer_Total !== 16'd0 || o_Drop_Total !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_stats: xfer=%0d drop=%0d, required 0 0", o_Xfer_Total, o_Drop_Total);
    end
`endif
  endtask

  task automatic test_basic();
    int dv0;
    int d0;
    reset_dut();
    dv0 = dv_count; d0 = done_count;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    do_xfer(2'd2, 2'd2, 8'hA5, 8'h3C, 1'b1, 0);
    n_cmp++;
    if (dv_count - dv0 !== 2 || done_count - d0 !== 1) begin
      n_bad++;
      $display("FAIL basic_counts: dvs=%0d dones=%0d, required 2 1", dv_count - dv0, done_count - d0);
    end
    drain(2);
  endtask

  task automatic test_cmd_err();
    int dv0;
    int e0;
    dv0 = dv_count; e0 = err_count;
    @(negedge clk);
    i_Cmd_Valid = 1'b1; i_Cmd_Slave = 2'd1; i_Cmd_Count = 2'd0;
    @(negedge clk);
    i_Cmd_Valid = 1'b0;
    n_cmp++;
    if (o_Cmd_Err !== 1'b1 || o_Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL err_count0: err=%b busy=%b, required 1 0", o_Cmd_Err, o_Busy);
    end
    @(negedge clk);
    n_cmp++;
    if (o_Cmd_Err !== 1'b0 || o_Cmd_Ready !== 1'b1) begin
      n_bad++;
      $display("FAIL err_pulse: err=%b cmd_ready=%b, required 0 1", o_Cmd_Err, o_Cmd_Ready);
    end
    i_Cmd_Valid = 1'b1; i_Cmd_Count = 2'd3;
    @(negedge clk);
    i_Cmd_Valid = 1'b0;
    n_cmp++;
    if (o_Cmd_Err !== 1'b1 || o_Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL err_count3: err=%b busy=%b, required 1 0", o_Cmd_Err, o_Busy);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (err_count - e0 !== 2 || dv_count !== dv0 || o_Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL err_summary: errs=%0d dvs=%0d busy=%b, required 2 0 0", err_count - e0, dv_count - dv0, o_Busy);
    end
  endtask

  task automatic test_stall();
    exp_q.push_back(8'hEE);
    exp_q.push_back(8'hDD);
    do_xfer(2'd1, 2'd2, 8'h11, 8'h22, 1'b0, 20);
    drain(2);
  endtask

  task automatic test_overflow();
    logic [7:0] a;
    logic [7:0] b;
    reset_dut();
    i_Rd_Ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = 8'h30 + 8'(k);
      b = 8'hC0 + 8'(k);
      if (k < 2) begin
        exp_q.push_back(~a);
        exp_q.push_back(~b);
      end
      do_xfer(2'(k), 2'd2, a, b, 1'b0, 0);
      if (k == 1) begin
        n_cmp++;
        if (o_Overflow !== 1'b0) begin
          n_bad++;
          $display("FAIL full_no_drop: o_Overflow=%b, required 0", o_Overflow);
        end
      end
    end
    n_cmp++;
    if (o_Overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow: o_Overflow=%b, required 1", o_Overflow);
    end
`ifdef SPI_XFER_SEQ_STATS_EN
    n_cmp++;
    if (o_Drop_Total !== 16'd2 || o_Xfer_Total !== 16'd3) begin
      n_bad++;
      $display("FAIL stats: drop=%0d xfer=%0d, required 2 3", o_Drop_Total, o_Xfer_Total);
    end
`endif
    drain(4);
  endtask

  task automatic test_back_to_back();
    int dv0;
    dv0 = dv_count;
    m_hold = 1'b1;
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'h7F);
    exp_q.push_back(8'h99);
    do_xfer(2'd3, 2'd2, 8'h01, 8'h80, 1'b0, 0);
    do_xfer(2'd0, 2'd1, 8'h66, 8'h00, 1'b0, 0);
    m_hold = 1'b0;
    n_cmp++;
    if (dv_count - dv0 !== 3) begin
      n_bad++;
      $display("FAIL b2b_dv_count: dvs=%0d, required 3", dv_count - dv0);
    end
    drain(3);
  endtask

  task automatic test_reset_mid();
    int t;
    int d0;
    d0 = done_count;
    @(negedge clk);
    i_Cmd_Valid = 1'b1; i_Cmd_Slave = 2'd3; i_Cmd_Count = 2'd2;
    i_Wr_Valid = 1'b1;  i_Wr_Byte = 8'h77;
    @(negedge clk);
    i_Cmd_Valid = 1'b0;
    t = 0;
    while (!o_TX_DV && t < 20) begin @(negedge clk); t++; end
    i_Wr_Valid = 1'b0;
    i_Rst = 1'b1;
    @(negedge clk);
    i_Rst = 1'b0;
    n_cmp++;
    if ({o_Cmd_Err, o_Wr_Ready, o_Rd_Valid, o_TX_DV, o_Busy, o_Done, o_Overflow, o_Cmd_Ready} !== 8'b0000_0001) begin
      n_bad++;
      $display("FAIL midreset_flags: err,wr,rd,dv,busy,done,ovf,cmd_rdy=%b, required 00000001",
               {o_Cmd_Err, o_Wr_Ready, o_Rd_Valid, o_TX_DV, o_Busy, o_Done, o_Overflow, o_Cmd_Ready});
    end
    n_cmp++;
    if (o_TX_Byte !== 8'h00 || o_TX_Count !== 2'd0 || o_Slave_Select !== 2'd0) begin
      n_bad++;
      $display("FAIL midreset_data: tx=%h cnt=%0d sel=%0d, required all 0", o_TX_Byte, o_TX_Count, o_Slave_Select);
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (o_Rd_Valid !== 1'b0 || o_Busy !== 1'b0 || done_count !== d0) begin
      n_bad++;
      $display("FAIL idle_rx_ignored: rd_valid=%b busy=%b dones=%0d, required 0 0 0", o_Rd_Valid, o_Busy, done_count - d0);
    end
    exp_q.delete();
  endtask

  initial begin
    i_Rst = 1'b1; i_Cmd_Valid = 1'b0; i_Cmd_Slave = 2'd0; i_Cmd_Count = 2'd0;
    i_Wr_Valid = 1'b0; i_Wr_Byte = 8'h00; i_Rd_Ready = 1'b0;
    test_reset();
    test_basic();
    test_cmd_err();
    test_stall();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
